vga_sync_decoder: RTL



---
 rtl/vga_sync_decoder_if.sv | 27 ++
 rtl/vga_sync_decoder.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/vga_sync_decoder_if.sv
// vga_sync_decoder_if: sync-side inputs and reconstructed raster outputs
// of the VGA sync decoder.
interface vga_sync_decoder_if;
  logic       pix_en;
  logic       hs;
  logic       vs;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       active;
  logic       locked;
  logic       frame_start;
  logic [9:0] h_total;
  logic [9:0] v_total;
  logic       timing_err;

  modport master (
    output pix_en, hs, vs,
    input  DrawX, DrawY, active, locked,
    input  frame_start, h_total, v_total, timing_err
  );

  modport slave (
    input  pix_en, hs, vs,
    output DrawX, DrawY, active, locked,
    output frame_start, h_total, v_total, timing_err
  );
endinterface

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: rebuilds DrawX/DrawY from hs/vs, measures line and
// frame periods, and declares lock on a matching raster.
module vga_sync_decoder #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int LOCK_FRAMES = 2
) (
  input logic Clk,
  input logic Reset_n,
  vga_sync_decoder_if.slave bus
);
  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [9:0] H_TOT  = 10'(HT);
  localparam logic [9:0] V_TOT  = 10'(VT);
  localparam logic [9:0] H_LAST = 10'(HT - 1);
  localparam logic [9:0] V_LAST = 10'(VT - 1);
  localparam logic [9:0] X_SYNC = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] Y_SYNC = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] X_VIS  = 10'(H_ACTIVE);
  localparam logic [9:0] Y_VIS  = 10'(V_ACTIVE);
  localparam logic [9:0] SAT    = 10'h3FF;
  localparam logic [2:0] GOOD_N = 3'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    UNLOCKED,
    ACQUIRE,
    LOCKED
  } state_t;

  state_t     state, nxt;
  logic [2:0] good, good_n;
  logic       hs_d, vs_d, h_bad;
  logic [9:0] x, y, hper, lcnt, h_tot, v_tot;
  logic [9:0] x_n, y_n, hmeas, lcnt_n;
  logic       tick, hs_fall, vs_fall, x_wrap;
  logic       h_err, v_bad, frame_ok;
  logic       fs, terr, lock;

  assign tick    = bus.pix_en;
  assign hs_fall = tick & hs_d & ~bus.hs;
  assign vs_fall = tick & vs_d & ~bus.vs;
  assign x_wrap  = tick & ~hs_fall & (x == H_LAST);

  assign hmeas  = (hper == SAT) ? SAT : hper + 10'd1;
  assign lcnt_n = (hs_fall && lcnt != SAT) ? lcnt + 10'd1 : lcnt;

  // hper at 1022 means this tick takes it to the 1023 ceiling: hs missing
  assign h_err = (hs_fall & (hmeas != H_TOT))
               | (tick & ~hs_fall & (hper >= 10'd1022));
  assign v_bad    = vs_fall & (lcnt_n != V_TOT);
  assign frame_ok = (lcnt_n == V_TOT) & ~h_bad & ~h_err;

  always_comb begin
    x_n = x;
    y_n = y;
    if (tick) begin
      if (hs_fall)     x_n = X_SYNC;
      else if (x_wrap) x_n = '0;
      else             x_n = x + 10'd1;
      if (vs_fall)     y_n = Y_SYNC;
      else if (x_wrap) y_n = (y == V_LAST) ? '0 : y + 10'd1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      hs_d  <= 1'b1;
      vs_d  <= 1'b1;
      x     <= '0;
      y     <= '0;
      hper  <= '0;
      lcnt  <= '0;
      h_tot <= '0;
      v_tot <= '0;
      h_bad <= 1'b0;
    end else if (tick) begin
      hs_d  <= bus.hs;
      vs_d  <= bus.vs;
      x     <= x_n;
      y     <= y_n;
      hper  <= hs_fall ? '0 : hmeas;
      lcnt  <= vs_fall ? '0 : lcnt_n;
      if (hs_fall) h_tot <= hmeas;
      if (vs_fall) v_tot <= lcnt_n;
      if (vs_fall)    h_bad <= 1'b0;
      else if (h_err) h_bad <= 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= UNLOCKED;
      good  <= '0;
      terr  <= 1'b0;
      fs    <= 1'b0;
    end else begin
      state <= nxt;
      good  <= good_n;
      terr  <= (state == LOCKED) & (nxt == UNLOCKED);
      fs    <= tick & (nxt == LOCKED) & (x_n == '0) & (y_n == '0);
    end
  end

  always_comb begin
    nxt    = state;
    good_n = good;
    unique case (state)
      UNLOCKED: begin
        if (vs_fall) begin
          nxt    = ACQUIRE;
          good_n = '0;
        end
      end
      ACQUIRE: begin
        if (vs_fall) begin
          if (frame_ok) begin
            good_n = good + 3'd1;
            if (good_n == GOOD_N) nxt = LOCKED;
          end else begin
            good_n = '0;
          end
        end
      end
      LOCKED: begin
        if (h_err || v_bad || (tick && lcnt > V_TOT))
          nxt = UNLOCKED;
      end
      default: nxt = UNLOCKED;
    endcase
  end

  always_comb begin
    lock = (state == LOCKED);
  end

  assign bus.DrawX       = x;
  assign bus.DrawY       = y;
  assign bus.locked      = lock;
  assign bus.active      = lock & (x < X_VIS) & (y < Y_VIS);
  assign bus.frame_start = fs;
  assign bus.timing_err  = terr;
  assign bus.h_total     = h_tot;
  assign bus.v_total     = v_tot;
endmodule
